vi_prbs_gen_chk: RTL and testbench
==================================

// Module: vi_prbs_gen_chk
// PURPOSE
//  Parametrised PRBS generator plus self-synchronising checker for link/datapath BIST.
//  Any WIDTH/TAPS polynomial is supported, and DATA_W bits are produced per enable.
//  The generator has seed load with lockup recovery; the checker has lock FSM and a saturating bit-error counter.
//  Sits beside the serdes/framer datapath; generator and checker are independent and loop back in test.
// PARAMETERS
//  WIDTH      32            LFSR length, 2..64
//  TAPS       32'h80200003  feedback mask; bit i set => lfsr[i] in XOR (default x^32+x^22+x^2+x^1+1)
//  DATA_W     8             bits generated/checked per beat, 1..WIDTH
//  LOCK_CNT   16            consecutive good words in VERIFY needed to lock
//  UNLOCK_CNT 4             consecutive bad words in LOCKED that drop lock
//  ERR_CNT_W  16            bit-error counter width
// PORTS
//  clk         in   1          clock
//  rst         in   1          asynchronous reset, active-high
//  gen_load    in   1          load gen_seed into generator LFSR
//  gen_seed    in   WIDTH      seed value
//  gen_en      in   1          advance generator DATA_W steps
//  gen_data    out  DATA_W     generated word; MSB = first bit generated
//  gen_valid   out  1          gen_data updated this cycle
//  gen_lockup  out  1          1-cycle pulse: all-zero seed was replaced
//  chk_valid   in   1          chk_data beat valid
//  chk_data    in   DATA_W     received word; MSB = first bit
//  err_clr     in   1          clear err_cnt
//  chk_locked  out  1          checker in LOCKED
//  chk_err     out  1          1-cycle pulse: last checked beat had >=1 bit error (VERIFY/LOCKED only)
//  err_cnt     out  ERR_CNT_W  saturating count of bit errors while LOCKED
// BEHAVIOUR
//  Reset: gen LFSR all 1s; gen_data=0, gen_valid=0, gen_lockup=0.
//    Checker: state SEARCH, chk LFSR all 1s, all counters 0, chk_locked=0, chk_err=0, err_cnt=0.
//  Step: fb = ^(lfsr & TAPS); lfsr <= {lfsr[WIDTH-2:0], fb}; output bit = fb.
//  Generator:
//    - gen_load has priority over gen_en.
//    - gen_seed==0 loads all 1s and pulses gen_lockup the next cycle.
//    - gen_en: next edge applies DATA_W steps; gen_data = the DATA_W fb bits; gen_valid=1 for that one cycle.
//    - Load has 1-cycle latency; gen_en in the cycle after load uses the new seed.
//  Checker FSM (transitions only on chk_valid beats):
//    SEARCH: shift received bits into chk LFSR (chk_data MSB first).
//      After ceil(WIDTH/DATA_W) beats -> VERIFY, good_cnt=0.
//    VERIFY: predict next word from chk LFSR.
//      Match -> advance LFSR by prediction, good_cnt++; good_cnt==LOCK_CNT -> LOCKED.
//      Mismatch -> SEARCH, beat counter=0 (the mismatching beat is not used as seed).
//    LOCKED: LFSR always advances by prediction, never by received data, so errors do not propagate.
//      err_cnt += popcount(chk_data ^ predicted).
//      bad_cnt++ on a mismatching word, cleared on a good word; bad_cnt==UNLOCK_CNT -> SEARCH.
//      err_cnt holds on exit.
//  Latency: chk_locked and chk_err are registered and valid the edge after the deciding beat.
//  err_cnt saturates at all 1s; no wrap.
//  err_clr with an error beat in the same cycle: err_cnt = that beat's popcount (saturated).
//  No chk_valid: no state, LFSR or counter change; chk_err=0.
//  rst mid-operation: all state returns to reset values immediately (async); no partial word output.
// TESTING
//  1. Reset; gen_load with seed 0 -> gen_lockup pulse; then LFSR == 0xFFFFFFFF and output matches golden model from all-1s.
//  2. Loop gen_data->chk_data with gen_en every cycle -> VERIFY after 4 beats; chk_locked=1 the edge after beat 20; err_cnt=0.
//  3. While locked, flip bit 3 of one word -> chk_err pulse once, err_cnt=1, chk_locked stays 1, next words clean.
//  4. While locked, corrupt 4 consecutive words -> chk_locked=0 after the 4th; clean data relocks 20 beats later.
//  5. ERR_CNT_W=4, inject 20 single-bit errors spread between good words -> err_cnt=15 (saturated);
//     err_clr plus a 2-bit error in the same cycle -> err_cnt=2.
//  6. Assert rst mid-stream with gen_en/chk_valid high -> all outputs at reset values; after release, relock in 20 beats.

Source files
------------

// File: rtl/vi_prbs_gen_chk.sv
// vi_prbs_gen_chk: PRBS generator plus self-synchronising checker for link/datapath BIST.
// The generator and checker share only the polynomial; in test they are looped back externally.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   gen_load        load gen_seed into the generator LFSR (priority over gen_en)
//   gen_seed        seed value; all-zero is replaced by all-ones and flagged on gen_lockup
//   gen_en          advance the generator DATA_W steps
//   gen_data        generated word, MSB = first bit generated
//   gen_valid       gen_data updated this cycle
//   gen_lockup      one-cycle pulse after an all-zero seed was replaced
//   chk_valid       chk_data beat valid
//   chk_data        received word, MSB = first bit
//   err_clr         clear err_cnt
//   chk_locked      checker is in LOCKED
//   chk_err         one-cycle pulse: last checked beat (VERIFY/LOCKED) had bit errors
//   err_cnt         saturating count of bit errors seen while LOCKED
module vi_prbs_gen_chk #(
    parameter int unsigned      WIDTH      = 32,
    parameter logic [WIDTH-1:0] TAPS       = 32'h80200003,
    parameter int unsigned      DATA_W     = 8,
    parameter int unsigned      LOCK_CNT   = 16,
    parameter int unsigned      UNLOCK_CNT = 4,
    parameter int unsigned      ERR_CNT_W  = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 gen_load,
    input  logic [WIDTH-1:0]     gen_seed,
    input  logic                 gen_en,
    output logic [DATA_W-1:0]    gen_data,
    output logic                 gen_valid,
    output logic                 gen_lockup,
    input  logic                 chk_valid,
    input  logic [DATA_W-1:0]    chk_data,
    input  logic                 err_clr,
    output logic                 chk_locked,
    output logic                 chk_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned SEARCH_BEATS = (WIDTH + DATA_W - 1) / DATA_W;
    localparam int unsigned BEAT_W       = $clog2(SEARCH_BEATS + 1);
    localparam int unsigned GOOD_W       = $clog2(LOCK_CNT + 1);
    localparam int unsigned BAD_W        = $clog2(UNLOCK_CNT + 1);
    localparam int unsigned POP_W        = $clog2(DATA_W + 1);
    localparam int unsigned SUM_W        = ERR_CNT_W + POP_W;
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = {ERR_CNT_W{1'b1}};

    typedef enum logic [1:0] {StSearch, StVerify, StLocked} chk_state_e;

    // Next DATA_W feedback bits from state s, first bit in the MSB.
    function automatic logic [DATA_W-1:0] prbs_word(input logic [WIDTH-1:0] s);
        logic [WIDTH-1:0]  st;
        logic              fb;
        logic [DATA_W-1:0] w;
        st = s;
        w  = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fb   = ^(st & TAPS);
            st   = {st[WIDTH-2:0], fb};
            w[i] = fb;
        end
        return w;
    endfunction

    // Shift a word into the state, MSB first. Shifting in prbs_word(s) equals stepping DATA_W times.
    function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] s,
                                                  input logic [DATA_W-1:0] d);
        logic [WIDTH-1:0] st;
        st = s;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            st = {st[WIDTH-2:0], d[i]};
        end
        return st;
    endfunction

    function automatic logic [POP_W-1:0] popcount(input logic [DATA_W-1:0] d);
        logic [POP_W-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_W; i++) begin
            c = c + POP_W'(d[i]);
        end
        return c;
    endfunction

    // ---------------- Generator ----------------
    logic [WIDTH-1:0]  gen_lfsr_q, gen_lfsr_d;
    logic [DATA_W-1:0] gen_data_q, gen_data_d, gen_word;
    logic              gen_valid_q, gen_valid_d, gen_lockup_q, gen_lockup_d;

    assign gen_word = prbs_word(gen_lfsr_q);

    always_comb begin
        gen_lfsr_d   = gen_lfsr_q;
        gen_data_d   = gen_data_q;
        gen_valid_d  = 1'b0;
        gen_lockup_d = 1'b0;
        if (gen_load) begin
            if (gen_seed == '0) begin
                gen_lfsr_d   = '1;
                gen_lockup_d = 1'b1;
            end else begin
                gen_lfsr_d = gen_seed;
            end
        end else if (gen_en) begin
            gen_lfsr_d  = shift_in(gen_lfsr_q, gen_word);
            gen_data_d  = gen_word;
            gen_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_lfsr_q   <= '1;
            gen_data_q   <= '0;
            gen_valid_q  <= 1'b0;
            gen_lockup_q <= 1'b0;
        end else begin
            gen_lfsr_q   <= gen_lfsr_d;
            gen_data_q   <= gen_data_d;
            gen_valid_q  <= gen_valid_d;
            gen_lockup_q <= gen_lockup_d;
        end
    end

    assign gen_data   = gen_data_q;
    assign gen_valid  = gen_valid_q;
    assign gen_lockup = gen_lockup_q;

    // ---------------- Checker ----------------
    chk_state_e               state_q, state_d;
    logic [WIDTH-1:0]         chk_lfsr_q, chk_lfsr_d;
    logic [BEAT_W-1:0]        beat_q, beat_d;
    logic [GOOD_W-1:0]        good_q, good_d;
    logic [BAD_W-1:0]         bad_q, bad_d;
    logic [ERR_CNT_W-1:0]     err_cnt_q, err_cnt_d, err_base;
    logic                     chk_err_q, chk_err_d;
    logic [DATA_W-1:0]        chk_pred, chk_diff;
    logic [POP_W-1:0]         chk_pop;
    logic [SUM_W-1:0]         err_sum;

    assign chk_pred = prbs_word(chk_lfsr_q);
    assign chk_diff = chk_data ^ chk_pred;
    assign chk_pop  = popcount(chk_diff);
    // A clear in the same cycle as an error beat restarts the count from that beat.
    assign err_base = err_clr ? '0 : err_cnt_q;
    assign err_sum  = SUM_W'(err_base) + SUM_W'(chk_pop);

    always_comb begin
        state_d    = state_q;
        chk_lfsr_d = chk_lfsr_q;
        beat_d     = beat_q;
        good_d     = good_q;
        bad_d      = bad_q;
        err_cnt_d  = err_base;
        chk_err_d  = 1'b0;
        if (chk_valid) begin
            unique case (state_q)
                StSearch: begin
                    chk_lfsr_d = shift_in(chk_lfsr_q, chk_data);
                    if (beat_q == BEAT_W'(SEARCH_BEATS - 1)) begin
                        state_d = StVerify;
                        beat_d  = '0;
                        good_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_W'(1);
                    end
                end
                StVerify: begin
                    chk_err_d = |chk_diff;
                    if (chk_diff == '0) begin
                        chk_lfsr_d = shift_in(chk_lfsr_q, chk_pred);
                        good_d     = good_q + GOOD_W'(1);
                        if (good_q == GOOD_W'(LOCK_CNT - 1)) begin
                            state_d = StLocked;
                            bad_d   = '0;
                        end
                    end else begin
                        // Mismatching beat is discarded; reseed from the following beats.
                        state_d = StSearch;
                        beat_d  = '0;
                    end
                end
                StLocked: begin
                    // Flywheel on the prediction so line errors never enter the LFSR.
                    chk_lfsr_d = shift_in(chk_lfsr_q, chk_pred);
                    chk_err_d  = |chk_diff;
                    err_cnt_d  = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_CNT_W-1:0];
                    if (chk_diff != '0) begin
                        bad_d = bad_q + BAD_W'(1);
                        if (bad_q == BAD_W'(UNLOCK_CNT - 1)) begin
                            state_d = StSearch;
                            beat_d  = '0;
                        end
                    end else begin
                        bad_d = '0;
                    end
                end
                default: begin
                    state_d = StSearch;
                    beat_d  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StSearch;
            chk_lfsr_q <= '1;
            beat_q     <= '0;
            good_q     <= '0;
            bad_q      <= '0;
            err_cnt_q  <= '0;
            chk_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            chk_lfsr_q <= chk_lfsr_d;
            beat_q     <= beat_d;
            good_q     <= good_d;
            bad_q      <= bad_d;
            err_cnt_q  <= err_cnt_d;
            chk_err_q  <= chk_err_d;
        end
    end

    assign chk_locked = (state_q == StLocked);
    assign chk_err    = chk_err_q;
    assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_vi_prbs_gen_chk.sv
// Bench for vi_prbs_gen_chk (ERR_CNT_W=4). The reference model treats the PRBS as a bit
// sequence defined by the recurrence s[n] = XOR of s[n-1-k] over set TAPS bits k, kept as
// bit-history queues; the checker model follows the SEARCH/VERIFY/LOCKED rules directly.
module tb_vi_prbs_gen_chk;
    localparam int W = 32, DW = 8, EW = 4;
    localparam int SB = (W + DW - 1) / DW;
    localparam int LOCK = 16, UNLOCK = 4;
    localparam int CNT_MAX = (1 << EW) - 1;
    localparam logic [31:0] TAPS_C = 32'h80200003;

    typedef bit bitq_t[$];

    logic          clk = 1'b0;
    logic          rst;
    logic          gen_load, gen_en, gen_valid, gen_lockup;
    logic [W-1:0]  gen_seed;
    logic [DW-1:0] gen_data, chk_data;
    logic          chk_valid, err_clr, chk_locked, chk_err;
    logic [EW-1:0] err_cnt;

    vi_prbs_gen_chk #(.WIDTH(W), .TAPS(TAPS_C), .DATA_W(DW), .LOCK_CNT(LOCK),
                      .UNLOCK_CNT(UNLOCK), .ERR_CNT_W(EW)) dut (
        .clk(clk), .rst(rst), .gen_load(gen_load), .gen_seed(gen_seed), .gen_en(gen_en),
        .gen_data(gen_data), .gen_valid(gen_valid), .gen_lockup(gen_lockup),
        .chk_valid(chk_valid), .chk_data(chk_data), .err_clr(err_clr),
        .chk_locked(chk_locked), .chk_err(chk_err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_miss = 0;

    // Reference model state
    bitq_t         ghist, chist;
    int            cm_state, cm_beats, cm_good, cm_bad;
    logic [EW-1:0] exp_cnt;
    bit            exp_err, exp_locked, exp_valid, exp_lockup;
    logic [DW-1:0] exp_data;

    function automatic bitq_t ones_hist();
        bitq_t h;
        for (int i = 0; i < W; i++) h.push_back(1'b1);
        return h;
    endfunction

    // Newest bit last; seed bit k is the bit emitted k steps ago.
    function automatic bitq_t seed_hist(input logic [W-1:0] s);
        bitq_t h;
        for (int k = W - 1; k >= 0; k--) h.push_back(s[k]);
        return h;
    endfunction

    function automatic bitq_t shifted(input bitq_t h, input logic [DW-1:0] w);
        bitq_t t;
        t = h;
        for (int i = DW - 1; i >= 0; i--) begin
            t.push_back(w[i]);
            void'(t.pop_front());
        end
        return t;
    endfunction

    function automatic logic [DW-1:0] prbs_next(input bitq_t h);
        bitq_t         t;
        logic [DW-1:0] w;
        bit            fb;
        t = h;
        for (int i = DW - 1; i >= 0; i--) begin
            fb = 1'b0;
            for (int k = 0; k < W; k++) if (TAPS_C[k]) fb ^= t[t.size() - 1 - k];
            t.push_back(fb);
            w[i] = fb;
        end
        return w;
    endfunction

    task automatic model_reset();
        ghist = ones_hist(); chist = ones_hist();
        cm_state = 0; cm_beats = 0; cm_good = 0; cm_bad = 0;
        exp_cnt = '0; exp_err = 0; exp_locked = 0; exp_valid = 0; exp_lockup = 0;
        exp_data = '0;
    endtask

    task automatic model_chk(input bit cv, input logic [DW-1:0] d, input bit clr);
        logic [DW-1:0] p;
        int            nerr, s;
        exp_err = 0;
        if (clr) exp_cnt = '0;
        if (cv) begin
            p    = prbs_next(chist);
            nerr = $countones(d ^ p);
            case (cm_state)
                0: begin
                    chist = shifted(chist, d);
                    cm_beats++;
                    if (cm_beats == SB) begin cm_state = 1; cm_good = 0; end
                end
                1: begin
                    if (nerr == 0) begin
                        chist = shifted(chist, p);
                        cm_good++;
                        if (cm_good == LOCK) begin cm_state = 2; cm_bad = 0; end
                    end else begin
                        exp_err = 1; cm_state = 0; cm_beats = 0;
                    end
                end
                default: begin
                    chist   = shifted(chist, p);
                    exp_err = (nerr != 0);
                    s       = int'(exp_cnt) + nerr;
                    exp_cnt = (s > CNT_MAX) ? EW'(CNT_MAX) : EW'(s);
                    if (nerr != 0) begin
                        cm_bad++;
                        if (cm_bad == UNLOCK) begin cm_state = 0; cm_beats = 0; end
                    end else begin
                        cm_bad = 0;
                    end
                end
            endcase
        end
        exp_locked = (cm_state == 2);
    endtask

    task automatic drive_idle();
        gen_load = 0; gen_seed = '0; gen_en = 0; chk_valid = 0; chk_data = '0; err_clr = 0;
    endtask

    // One cycle of loopback: the word the generator emits is also presented to the checker.
    task automatic beat(input bit en, input logic [DW-1:0] mask, input bit clr);
        logic [DW-1:0] w, d;
        w = prbs_next(ghist);
        d = en ? (w ^ mask) : DW'($urandom);
        gen_load = 0; gen_en = en; chk_valid = en; chk_data = d; err_clr = clr;
        @(posedge clk); #1;
        if (en) begin ghist = shifted(ghist, w); exp_data = w; end
        exp_valid = en; exp_lockup = 0;
        model_chk(en, d, clr);
        gen_en = 0; chk_valid = 0; err_clr = 0;
    endtask

    task automatic load(input logic [W-1:0] seed);
        gen_load = 1; gen_seed = seed; gen_en = 1; chk_valid = 0; err_clr = 0;
        @(posedge clk); #1;
        gen_load = 0; gen_en = 0;
        ghist = (seed == '0) ? ones_hist() : seed_hist(seed);
        exp_valid = 0; exp_lockup = (seed == '0);
        model_chk(0, '0, 0);
    endtask

    task automatic apply_reset();
        rst = 1; drive_idle();
        repeat (2) @(posedge clk);
        #1; rst = 0;
        model_reset();
    endtask

    task automatic test_reset();
        rst = 1; gen_en = 1; chk_valid = 1; chk_data = DW'($urandom); err_clr = 0;
        gen_load = 0; gen_seed = W'($urandom);
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({gen_data, gen_valid, gen_lockup, chk_locked, chk_err, err_cnt} !== '0) begin
            n_miss++;
            $display("FAIL reset_state: got data=%h valid=%b lockup=%b locked=%b err=%b cnt=%0d, want all 0",
                     gen_data, gen_valid, gen_lockup, chk_locked, chk_err, err_cnt);
        end
        rst = 0; drive_idle(); model_reset();
    endtask

    task automatic test_gen_load();
        logic [W-1:0] seed;
        seed = W'($urandom) | 32'h1;
        load(seed);  // gen_en also high: load must win
        n_vec++;
        if (gen_valid !== 1'b0 || gen_lockup !== 1'b0 || gen_data !== exp_data) begin
            n_miss++;
            $display("FAIL load_priority: got valid=%b lockup=%b data=%h, want 0 0 %h",
                     gen_valid, gen_lockup, gen_data, exp_data);
        end
        for (int i = 0; i < 8; i++) begin
            beat(1, '0, 0);
            n_vec++;
            if (gen_valid !== 1'b1 || gen_data !== exp_data) begin
                n_miss++;
                $display("FAIL seed_stream beat %0d: got valid=%b data=%h, want 1 %h",
                         i, gen_valid, gen_data, exp_data);
            end
        end
        load('0);
        n_vec++;
        if (gen_lockup !== 1'b1 || gen_valid !== 1'b0) begin
            n_miss++;
            $display("FAIL lockup_pulse: got lockup=%b valid=%b, want 1 0", gen_lockup, gen_valid);
        end
        beat(1, '0, 0);
        n_vec++;
        if (gen_lockup !== 1'b0 || gen_data !== 8'h6D || gen_data !== exp_data) begin
            n_miss++;
            $display("FAIL ones_first_word: got lockup=%b data=%h, want 0 6d (model %h)",
                     gen_lockup, gen_data, exp_data);
        end
        for (int i = 0; i < 8; i++) begin
            beat(($urandom_range(0, 2) != 0), '0, 0);
            n_vec++;
            if (gen_valid !== exp_valid || gen_data !== exp_data || gen_lockup !== 1'b0) begin
                n_miss++;
                $display("FAIL ones_stream beat %0d: got valid=%b data=%h, want %b %h",
                         i, gen_valid, gen_data, exp_valid, exp_data);
            end
        end
    endtask

    task automatic test_lock();
        apply_reset();
        for (int i = 1; i <= 24; i++) begin
            beat(1, '0, 0);
            n_vec++;
            if (chk_locked !== (i >= SB + LOCK) || chk_locked !== exp_locked ||
                chk_err !== 1'b0 || err_cnt !== '0 || gen_data !== exp_data) begin
                n_miss++;
                $display("FAIL lock_seq beat %0d: got locked=%b err=%b cnt=%0d data=%h, want %b 0 0 %h",
                         i, chk_locked, chk_err, err_cnt, gen_data, (i >= SB + LOCK), exp_data);
            end
        end
    endtask

    task automatic test_single_err();
        beat(1, 8'h08, 0);
        n_vec++;
        if (chk_err !== 1'b1 || err_cnt !== 4'd1 || chk_locked !== 1'b1 || err_cnt !== exp_cnt) begin
            n_miss++;
            $display("FAIL single_err: got err=%b cnt=%0d locked=%b, want 1 1 1", chk_err, err_cnt, chk_locked);
        end
        for (int i = 0; i < 6; i++) begin
            beat(($urandom_range(0, 3) != 0), '0, 0);
            n_vec++;
            if (chk_err !== 1'b0 || err_cnt !== 4'd1 || chk_locked !== 1'b1) begin
                n_miss++;
                $display("FAIL after_single_err %0d: got err=%b cnt=%0d locked=%b, want 0 1 1",
                         i, chk_err, err_cnt, chk_locked);
            end
        end
    endtask

    task automatic test_unlock();
        for (int i = 1; i <= UNLOCK; i++) begin
            beat(1, DW'($urandom_range(1, 255)), 0);
            n_vec++;
            if (chk_locked !== (i < UNLOCK) || chk_err !== 1'b1 || err_cnt !== exp_cnt) begin
                n_miss++;
                $display("FAIL unlock bad %0d: got locked=%b err=%b cnt=%0d, want %b 1 %0d",
                         i, chk_locked, chk_err, err_cnt, (i < UNLOCK), exp_cnt);
            end
        end
        for (int i = 1; i <= 24; i++) begin
            beat(1, '0, 0);
            n_vec++;
            if (chk_locked !== (i >= SB + LOCK) || chk_err !== 1'b0 || err_cnt !== exp_cnt) begin
                n_miss++;
                $display("FAIL relock beat %0d: got locked=%b err=%b cnt=%0d, want %b 0 %0d",
                         i, chk_locked, chk_err, err_cnt, (i >= SB + LOCK), exp_cnt);
            end
        end
    endtask

    task automatic test_saturate();
        int a, b;
        beat(1, '0, 1);
        n_vec++;
        if (err_cnt !== '0 || chk_locked !== 1'b1) begin
            n_miss++;
            $display("FAIL clear: got cnt=%0d locked=%b, want 0 1", err_cnt, chk_locked);
        end
        for (int e = 1; e <= 20; e++) begin
            beat(1, DW'(1 << $urandom_range(0, DW - 1)), 0);
            n_vec++;
            if (err_cnt !== exp_cnt || err_cnt !== ((e > CNT_MAX) ? EW'(CNT_MAX) : EW'(e)) ||
                chk_err !== 1'b1 || chk_locked !== 1'b1) begin
                n_miss++;
                $display("FAIL sat_count err %0d: got cnt=%0d err=%b locked=%b, want %0d 1 1",
                         e, err_cnt, chk_err, chk_locked, exp_cnt);
            end
            repeat ($urandom_range(1, 3)) beat(1, '0, 0);
        end
        n_vec++;
        if (err_cnt !== 4'd15) begin
            n_miss++;
            $display("FAIL saturated: got cnt=%0d, want 15", err_cnt);
        end
        a = $urandom_range(0, DW - 1);
        b = (a + 1 + $urandom_range(0, DW - 2)) % DW;
        beat(1, DW'((1 << a) | (1 << b)), 1);
        n_vec++;
        if (err_cnt !== 4'd2 || chk_err !== 1'b1) begin
            n_miss++;
            $display("FAIL clr_with_err: got cnt=%0d err=%b, want 2 1", err_cnt, chk_err);
        end
        beat(0, '0, 1);
        n_vec++;
        if (err_cnt !== 4'd0 || chk_err !== 1'b0 || chk_locked !== 1'b1) begin
            n_miss++;
            $display("FAIL clr_idle: got cnt=%0d err=%b locked=%b, want 0 0 1", err_cnt, chk_err, chk_locked);
        end
    endtask

    task automatic test_random();
        bit            en, clr;
        logic [DW-1:0] mask;
        for (int i = 0; i < 400; i++) begin
            en   = ($urandom_range(0, 3) != 0);
            mask = ($urandom_range(0, 7) == 0) ? DW'($urandom) : '0;
            clr  = ($urandom_range(0, 39) == 0);
            beat(en, mask, clr);
            n_vec++;
            if ({chk_locked, chk_err, err_cnt, gen_valid, gen_data} !==
                {exp_locked, exp_err, exp_cnt, exp_valid, exp_data}) begin
                n_miss++;
                $display("FAIL random beat %0d: got locked=%b err=%b cnt=%0d valid=%b data=%h, want %b %b %0d %b %h",
                         i, chk_locked, chk_err, err_cnt, gen_valid, gen_data,
                         exp_locked, exp_err, exp_cnt, exp_valid, exp_data);
            end
        end
    endtask

    task automatic test_reset_mid();
        int guard;
        guard = 0;
        while (!exp_locked && guard < 40) begin
            beat(1, '0, 0);
            guard++;
        end
        beat(1, 8'h01, 0);
        gen_en = 1; chk_valid = 1; chk_data = DW'($urandom);
        @(posedge clk);
        #3 rst = 1;
        #1;
        n_vec++;
        if ({gen_data, gen_valid, gen_lockup, chk_locked, chk_err, err_cnt} !== '0) begin
            n_miss++;
            $display("FAIL reset_mid: got data=%h valid=%b lockup=%b locked=%b err=%b cnt=%0d, want all 0",
                     gen_data, gen_valid, gen_lockup, chk_locked, chk_err, err_cnt);
        end
        @(posedge clk);
        #1 rst = 0;
        drive_idle(); model_reset();
        for (int i = 1; i <= 22; i++) begin
            beat(1, '0, 0);
            n_vec++;
            if (chk_locked !== (i >= SB + LOCK) || chk_locked !== exp_locked || gen_data !== exp_data) begin
                n_miss++;
                $display("FAIL relock_after_rst beat %0d: got locked=%b data=%h, want %b %h",
                         i, chk_locked, gen_data, (i >= SB + LOCK), exp_data);
            end
        end
    endtask

    initial begin
        drive_idle();
        model_reset();
        test_reset();
        test_gen_load();
        test_lock();
        test_single_err();
        test_unlock();
        test_saturate();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
